// File: rtl/mcbsp_pkg.sv
// rtl/mcbsp_pkg.sv - shared defaults, FSM state type and frame word slicing for the McBSP unpacker
package mcbsp_pkg;

    localparam int DEFAULT_WORDS_PER_FRAME = 8;
    localparam int DEFAULT_BITS_PER_WORD   = 32;
    localparam int DEFAULT_FRAME_BITS      = DEFAULT_WORDS_PER_FRAME * DEFAULT_BITS_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SAMPLE_A = 3'd2,
        ST_SAMPLE_B = 3'd3,
        ST_COMMIT   = 3'd4
    } unpack_state_t;

    // Word 0 occupies the most significant bits of the frame.
    function automatic logic [DEFAULT_BITS_PER_WORD-1:0] frame_word(
        input logic [DEFAULT_FRAME_BITS-1:0] frame,
        input int unsigned                   idx
    );
        return frame[(DEFAULT_WORDS_PER_FRAME - idx) * DEFAULT_BITS_PER_WORD - 1 -: DEFAULT_BITS_PER_WORD];
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - two-flop single-bit synchronizer with configurable reset value
module cdc_sync_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcbsp_frame_unpacker.sv
// rtl/mcbsp_frame_unpacker.sv - captures a settled McBSP frame, commits it and streams its words
module mcbsp_frame_unpacker
    import mcbsp_pkg::*;
#(
    parameter int WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME,
    parameter int BITS_PER_WORD   = DEFAULT_BITS_PER_WORD,
    parameter int SETTLE_CYCLES   = 16,
    parameter int MAX_RETRY       = 3,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                                     a_clk,
    input  logic                                     a_reset,
    input  logic                                     mcbsp_data_frm,
    input  logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] dataset_read,
    output logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] dataset_out,
    output logic                                     dataset_valid,
    output logic [BITS_PER_WORD-1:0]                 M_AXIS_tdata,
    output logic                                     M_AXIS_tvalid,
    input  logic                                     M_AXIS_tready,
    output logic                                     M_AXIS_tlast,
    output logic [31:0]                              frame_count,
    output logic [15:0]                              error_count,
    output logic                                     overrun,
    output logic                                     link_timeout
);

    localparam int DATA_W = WORDS_PER_FRAME * BITS_PER_WORD;
    localparam int IDX_W  = $clog2(WORDS_PER_FRAME);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    logic              frm_sync;
    logic              frm_sync_d;
    logic              fall_r;
    unpack_state_t     state;
    logic [7:0]        settle_cnt;
    logic [7:0]        retry_cnt;
    logic [DATA_W-1:0] smp_a;
    logic [DATA_W-1:0] stream_buf;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic [TO_W-1:0]   to_cnt;
    logic              commit;
    logic              beat;
    logic              stream_free;

    // Idle-safe reset of 1 keeps a low line at reset release from reading as a frame end.
    cdc_sync_bit #(.RESET_VALUE(1'b1)) u_frm_sync (
        .clk (a_clk),
        .rst (a_reset),
        .d   (mcbsp_data_frm),
        .q   (frm_sync)
    );

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            frm_sync_d <= 1'b1;
            fall_r     <= 1'b0;
        end else begin
            frm_sync_d <= frm_sync;
            fall_r     <= frm_sync_d & ~frm_sync;
        end
    end

    // Commit side effects land on the edge entering COMMIT so the frame and its pulse are visible during COMMIT.
    assign commit = (state == ST_SAMPLE_B) && (dataset_read == smp_a);

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            retry_cnt     <= '0;
            smp_a         <= '0;
            dataset_out   <= '0;
            dataset_valid <= 1'b0;
            frame_count   <= '0;
            error_count   <= '0;
        end else begin
            dataset_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall_r) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 8'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= ST_SAMPLE_A;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                ST_SAMPLE_A: begin
                    smp_a <= dataset_read;
                    state <= ST_SAMPLE_B;
                end
                ST_SAMPLE_B: begin
                    if (commit) begin
                        state         <= ST_COMMIT;
                        dataset_out   <= smp_a;
                        dataset_valid <= 1'b1;
                        frame_count   <= frame_count + 32'd1;
                    end else if (retry_cnt < 8'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 8'd1;
                        state     <= ST_SAMPLE_A;
                    end else begin
                        retry_cnt <= '0;
                        if (error_count != 16'hFFFF) begin
                            error_count <= error_count + 16'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    retry_cnt <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A final beat in the commit cycle frees the buffer, so the new frame loads instead of overrunning.
    assign beat        = busy && M_AXIS_tready;
    assign stream_free = !busy || (beat && (idx == LAST_IDX));

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            busy       <= 1'b0;
            idx        <= '0;
            stream_buf <= '0;
            overrun    <= 1'b0;
        end else begin
            if (commit && stream_free) begin
                stream_buf <= smp_a;
                idx        <= '0;
                busy       <= 1'b1;
            end else if (beat) begin
                if (idx == LAST_IDX) begin
                    busy <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (commit && !stream_free) begin
                overrun <= 1'b1;
            end
        end
    end

    assign M_AXIS_tvalid = busy;
    assign M_AXIS_tdata  = frame_word(stream_buf, 32'(idx));
    assign M_AXIS_tlast  = busy && (idx == LAST_IDX);

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            to_cnt <= '0;
        end else if (fall_r) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign link_timeout = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_mcbsp_frame_unpacker.sv
// tb/tb_mcbsp_frame_unpacker.sv - randomized scoreboard bench for mcbsp_frame_unpacker
module tb_mcbsp_frame_unpacker;

    localparam int SETTLE = 16;
    localparam int TMO    = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frm = 1'b1;
    logic [255:0] din = '0;
    logic         tready = 1'b1;
    logic [255:0] dout;
    logic         dvalid;
    logic [31:0]  tdata;
    logic         tvalid;
    logic         tlast;
    logic [31:0]  frame_count;
    logic [15:0]  error_count;
    logic         overrun;
    logic         link_timeout;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t        word_q[$];
    logic [255:0] frame_q[$];
    int checks = 0;
    int errors = 0;
    int tready_mode = 0;
    bit toggle_en = 1'b0;
    int commits_seen = 0;

    mcbsp_frame_unpacker #(
        .SETTLE_CYCLES  (SETTLE),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .a_clk          (clk),
        .a_reset        (rst),
        .mcbsp_data_frm (frm),
        .dataset_read   (din),
        .dataset_out    (dout),
        .dataset_valid  (dvalid),
        .M_AXIS_tdata   (tdata),
        .M_AXIS_tvalid  (tvalid),
        .M_AXIS_tready  (tready),
        .M_AXIS_tlast   (tlast),
        .frame_count    (frame_count),
        .error_count    (error_count),
        .overrun        (overrun),
        .link_timeout   (link_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event", name);
    endtask

    function automatic logic [31:0] model_word(input logic [255:0] f, input int i);
        return 32'(f >> (32 * (7 - i)));
    endfunction

    function automatic void expect_frame(input logic [255:0] f, input bit streamed);
        frame_q.push_back(f);
        if (streamed) begin
            for (int i = 0; i < 8; i++) begin
                beat_t b;
                b.data = model_word(f, i);
                b.last = (i == 7);
                word_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [255:0] rand_frame();
        logic [255:0] f = '0;
        for (int i = 0; i < 8; i++) f = {f[223:0], 32'($urandom())};
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop_frame(output int lat, output logic lt3, output logic lt4,
                              output logic tv21, output logic tv_on);
        lat = -1; lt3 = 1'b0; lt4 = 1'b0; tv21 = 1'b0; tv_on = 1'b0;
        frm = 1'b0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 3)  lt3 = link_timeout;
            if (n == 4)  lt4 = link_timeout;
            if (n == 21) tv21 = tvalid;
            if (dvalid) begin
                lat   = n;
                tv_on = tvalid;
            end
        end
    endtask

    task automatic send_frame(input logic [255:0] f, output int lat);
        logic a, b, c, d;
        din = f;
        frm = 1'b1;
        tick(4);
        drop_frame(lat, a, b, c, d);
    endtask

    // Input drivers: tready policy and dataset bit-0 instability
    initial forever begin
        @(posedge clk);
        #1;
        case (tready_mode)
            0:       tready = 1'b1;
            1:       tready = 1'b0;
            default: tready = 1'($urandom_range(0, 1));
        endcase
        if (toggle_en) din[0] = ~din[0];
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a commit
    always @(negedge clk) begin
        beat_t b;
        logic [255:0] f;
        if (!rst) begin
            if (tvalid && tready) begin
                if (word_q.size() == 0) begin
                    fail_now("stream_beat_unexpected");
                end else begin
                    b = word_q.pop_front();
                    check("tdata", 256'(tdata), 256'(b.data));
                    check("tlast", 256'(tlast), 256'(b.last));
                end
            end
            if (dvalid) begin
                commits_seen++;
                if (frame_q.size() == 0) begin
                    fail_now("commit_unexpected");
                end else begin
                    f = frame_q.pop_front();
                    check("dataset_out", dout, f);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic lt3, lt4, tv21, tv_on;
        logic [255:0] f1, f2, f3, f4, f5, f6, f7, f;

        f1 = {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
              32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        din = f1;
        tick(3);
        check("rst_dataset_out", dout, '0);
        check("rst_dataset_valid", 256'(dvalid), 0);
        check("rst_tvalid", 256'(tvalid), 0);
        check("rst_tdata", 256'(tdata), 0);
        check("rst_tlast", 256'(tlast), 0);
        check("rst_frame_count", 256'(frame_count), 0);
        check("rst_error_count", 256'(error_count), 0);
        check("rst_overrun", 256'(overrun), 0);
        check("rst_link_timeout", 256'(link_timeout), 0);
        rst = 1'b0;

        // Timeout: counter runs from release with frm held high
        for (int n = 1; n <= TMO; n++) begin
            tick(1);
            if (n == TMO - 1) check("timeout_before", 256'(link_timeout), 0);
            if (n == TMO)     check("timeout_at_limit", 256'(link_timeout), 1);
        end
        check("no_spurious_commit", 256'(frame_count), 0);

        // Basic frame with known pattern; also clears the timeout
        expect_frame(f1, 1'b1);
        drop_frame(lat, lt3, lt4, tv21, tv_on);
        check("timeout_held_k2", 256'(lt3), 1);
        check("timeout_cleared_k3", 256'(lt4), 0);
        check("basic_latency", 256'(lat), 256'(SETTLE + 6));
        check("tvalid_before_commit", 256'(tv21), 0);
        check("tvalid_with_valid", 256'(tv_on), 1);
        tick(12);
        check("basic_frame_count", 256'(frame_count), 1);
        check("basic_stream_drained", 256'(word_q.size()), 0);

        // Unstable bus: every sample pair differs
        f2 = rand_frame();
        din = f2;
        frm = 1'b1;
        tick(4);
        frm = 1'b0;
        toggle_en = 1'b1;
        tick(45);
        toggle_en = 1'b0;
        tick(2);
        check("unstable_error_count", 256'(error_count), 1);
        check("unstable_no_commit", 256'(commits_seen), 1);
        check("unstable_frame_count", 256'(frame_count), 1);
        f3 = rand_frame();
        expect_frame(f3, 1'b1);
        send_frame(f3, lat);
        check("recover_latency", 256'(lat), 256'(SETTLE + 6));
        tick(12);
        check("recover_frame_count", 256'(frame_count), 2);

        // Overrun: two frames with the stream stalled
        tready_mode = 1;
        tick(1);
        f4 = rand_frame();
        f5 = rand_frame();
        expect_frame(f4, 1'b1);
        send_frame(f4, lat);
        check("ovr_first_latency", 256'(lat), 256'(SETTLE + 6));
        check("ovr_not_yet", 256'(overrun), 0);
        expect_frame(f5, 1'b0);
        send_frame(f5, lat);
        check("ovr_second_latency", 256'(lat), 256'(SETTLE + 6));
        check("ovr_flag", 256'(overrun), 1);
        check("ovr_dataset_out", dout, f5);
        check("ovr_stalled_tdata", 256'(tdata), 256'(model_word(f4, 0)));
        tready_mode = 0;
        tick(12);
        check("ovr_stream_drained", 256'(word_q.size()), 0);

        // Reset while word 3 is on the stream
        f6 = rand_frame();
        expect_frame(f6, 1'b1);
        send_frame(f6, lat);
        tick(3);
        check("mid_stream_word3", 256'(tdata), 256'(model_word(f6, 3)));
        #2;
        rst = 1'b1;
        frm = 1'b1;
        word_q.delete();
        #1;
        check("rst_async_tvalid", 256'(tvalid), 0);
        check("rst_async_frame_count", 256'(frame_count), 0);
        check("rst_async_error_count", 256'(error_count), 0);
        check("rst_async_overrun", 256'(overrun), 0);
        check("rst_async_dataset_out", dout, '0);
        tick(3);
        rst = 1'b0;
        tick(5);
        f7 = rand_frame();
        expect_frame(f7, 1'b1);
        send_frame(f7, lat);
        check("post_rst_latency", 256'(lat), 256'(SETTLE + 6));
        tick(12);
        check("post_rst_frame_count", 256'(frame_count), 1);

        // Random backpressure over 100 spaced frames
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        tready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            f = rand_frame();
            expect_frame(f, 1'b1);
            din = f;
            frm = 1'b1;
            tick(4);
            frm = 1'b0;
            tick(196);
        end
        tready_mode = 0;
        tick(20);
        check("rand_frame_count", 256'(frame_count), 100);
        check("rand_words_left", 256'(word_q.size()), 0);
        check("rand_commits_left", 256'(frame_q.size()), 0);
        check("rand_error_count", 256'(error_count), 0);
        check("rand_overrun", 256'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcbsp_frame_unpacker.md
# mcbsp_frame_unpacker

Receive-side companion of the McBSP serial link. Takes the asynchronous frame flag and the 256-bit received dataset from the McBSP link into the `a_clk` domain, checks that the bus is stable, and commits it as a parallel snapshot. Also emits an AXI4-Stream of the 8 words for the PS/DMA path and keeps link-health counters.

## Interface
- `WORDS_PER_FRAME`, 8, words per McBSP frame.
- `BITS_PER_WORD`, 32, bits per word; stream width equals this.
- `SETTLE_CYCLES`, 16, `a_clk` cycles waited after frame end before sampling; legal range 1..255.
- `MAX_RETRY`, 3, extra A/B sample attempts before a frame is dropped.
- `TIMEOUT_CYCLES`, 1048576, `a_clk` cycles without a frame end before `link_timeout` is raised.

Ports:
- `a_clk` in 1: the only clock.
- `a_reset` in 1: asynchronous, active-high reset.
- `mcbsp_data_frm` in 1: frame-active flag from the McBSP domain; asynchronous.
- `dataset_read` in 256: received frame from the McBSP domain; quasi-static, asynchronous. Word 0 is bits [255:224].
- `dataset_out` out 256: last committed frame.
- `dataset_valid` out 1: one-cycle pulse when `dataset_out` updates.
- `M_AXIS_tdata` out 32: streamed word.
- `M_AXIS_tvalid` out 1: stream valid.
- `M_AXIS_tready` in 1: stream ready.
- `M_AXIS_tlast` out 1: high on word 7.
- `frame_count` out 32: committed frames; wraps.
- `error_count` out 16: dropped frames (unstable bus); saturates at 0xFFFF.
- `overrun` out 1: sticky; set when a commit arrives while the stream is busy.
- `link_timeout` out 1: no frame end for `TIMEOUT_CYCLES`.

## Operation
- `mcbsp_data_frm` passes through a 2-FF synchronizer. A registered falling-edge detect, `fall_r`, marks frame end.
- FSM states: IDLE, SETTLE, SAMPLE_A, SAMPLE_B, COMMIT.
  - IDLE, on `fall_r`: go to SETTLE and load the counter with `SETTLE_CYCLES-1`.
  - SETTLE: decrement the counter. At 0, go to SAMPLE_A.
  - SAMPLE_A: register `dataset_read` into `smp_a`, then go to SAMPLE_B.
  - SAMPLE_B: compare `dataset_read` with `smp_a`.
    - Equal: go to COMMIT.
    - Unequal with retry count below `MAX_RETRY`: increment the retry count and go back to SAMPLE_A.
    - Unequal with retries exhausted: increment `error_count` and go to IDLE.
  - COMMIT: `dataset_out <= smp_a`, pulse `dataset_valid`, increment `frame_count`, clear the retry count, go to IDLE.
- A `fall_r` outside IDLE is ignored. The McBSP side only updates `dataset_read` after a frame end, so the pending sample stays valid.
- Stream engine, separate from the FSM:
  - In COMMIT with the stream idle: copy the frame to `stream_buf` and set index 0.
  - A word transfers when `tvalid && tready`; the index then increments.
  - `tlast` is high while the index is 7. After word 7 transfers, the stream goes idle.
  - In COMMIT with the stream busy: the stream is not restarted and `overrun` is set; `dataset_out` still updates.
- `tvalid`, once asserted, stays high and `tdata`/`tlast` stay stable until the transfer.
- Timeout counter:
  - Cleared on `fall_r`, otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - `link_timeout` is high while the counter equals `TIMEOUT_CYCLES`.
  - The next `fall_r` clears `link_timeout`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronizer FFs 1 (frame-active idle-safe), stream idle, timeout counter 0.
- Edge k is the first `a_clk` edge that samples `mcbsp_data_frm` low. Then:
  - `fall_r` is high after edge k+2.
  - SETTLE is entered at k+3.
  - SAMPLE_A at k+3+`SETTLE_CYCLES`, SAMPLE_B one edge later, COMMIT one edge after that.
  - `dataset_valid` is high for the single cycle following edge k+`SETTLE_CYCLES`+5, with no retries.
- Each retry adds 2 cycles.
- First `M_AXIS_tvalid` rises in the same cycle as `dataset_valid`.
- With `tready` held high, the 8 words transfer in 8 consecutive cycles.
- Simultaneous stream-done (word 7 transferring) and COMMIT: treated as stream idle. The new frame loads and no overrun is flagged.
- `a_reset` asserted mid-frame or mid-stream aborts immediately. `tvalid` drops asynchronously and the counters clear.

## Structure
- Package `mcbsp_pkg` holds:
  - `WORDS_PER_FRAME` and `BITS_PER_WORD` defaults.
  - The FSM state enum `unpack_state_t`.
  - A word-index slicing function, so word i = bits [(8-i)*32-1 -: 32].
- Sub-module `cdc_sync_bit` (2-FF synchronizer with reset value parameter) is used for `mcbsp_data_frm`.
- The stream engine and timeout counter are inline.

## Test plan
- Drive `dataset_read` = 0x00000000_11111111_…_77777777, drop `frm`, keep `tready`=1.
  - `dataset_valid` at k+21 with `SETTLE_CYCLES`=16.
  - Stream 0x0,0x11111111…0x77777777, `tlast` on the 8th word, `frame_count`=1.
- Toggle bit 0 of `dataset_read` every cycle across 4 sample pairs.
  - No `dataset_valid`, `error_count`=1, FSM back in IDLE.
  - The next clean frame commits normally.
- Hold `tready`=0 and send 2 frames.
  - `overrun`=1 and `dataset_out` equals frame 2.
  - After `tready`=1, the stream still delivers frame 1's 8 words.
- Keep `frm` high for `TIMEOUT_CYCLES` (reduce it to 64 for the run).
  - `link_timeout`=1 at cycle 64; cleared 3 cycles after `frm` falls.
- Assert `a_reset` during word 3 of a stream.
  - `tvalid`=0 immediately, all counters 0.
  - After release, the first frame end commits with `frame_count`=1.
- Random `tready` backpressure over 100 frames spaced 200 cycles apart: every word is received in order, and `frame_count`=100.
